// File: rtl/apb_requester.sv
// APB initiator: valid/ready commands in, single APB transfers out,
// completions returned on a valid/ready response channel.
module apb_requester #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;

    logic              timeout_hit_d;
    logic [CNT_W-1:0]  cnt_d;

    assign cnt_d         = cnt_q + CNT_W'(1);
    assign timeout_hit_d = TO_EN && (cnt_q == CNT_LAST);

    // Gated by reset so no command is taken while the block is held.
    assign cmd_ready   = (state_q == IDLE) && preset_n;

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr_q   <= cmd_addr;
                        pwrite_q  <= cmd_write;
                        pwdata_q  <= cmd_wdata;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A ready completer takes priority over a coincident timeout.
                    if (pready) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= (!pwrite_q && !pslverr) ?
                                         prdata : '0;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                        if (timeout_hit_d) begin
                            psel_q        <= 1'b0;
                            penable_q     <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_err_q     <= 1'b1;
                            rsp_timeout_q <= 1'b1;
                            rsp_rdata_q   <= '0;
                            state_q       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: vector table with a small
// completer driver, plus reset-in-ACCESS sequence.
module tb_apb_requester;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          pclk;
    logic          preset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    int tests;
    int fails;

    apb_requester #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .pclk       (pclk),
        .preset_n   (preset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prd;
        logic          slverr;
        int            hold;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic          exp_to;
        int            exp_psel;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // penable without psel is never legal outside reset
    always @(negedge pclk) begin
        if (preset_n)
            chk("penable_implies_psel", {31'b0, penable & ~psel}, 32'd0);
    end

    task automatic run(input vec_t v);
        int a;
        int pcyc;
        bit done;
        @(negedge pclk);
        chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        chk("psel_idle", {31'b0, psel}, 32'd0);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        cmd_write = ~v.wr;
        chk("setup_phase", {30'b0, psel, penable}, 32'd2);
        chk("setup_addr", {16'b0, paddr}, {16'b0, v.addr});
        pcyc = 1;
        a = 0;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge pclk);
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                chk("access_phase", {30'b0, psel, penable}, 32'd3);
                chk("access_addr", {16'b0, paddr}, {16'b0, v.addr});
                chk("access_write", {31'b0, pwrite}, {31'b0, v.wr});
                chk("access_wdata", pwdata, v.wdata);
                pready  = (a == v.waits);
                prdata  = pready ? v.prd : (32'hBAD0_0000 | a);
                pslverr = pready ? v.slverr : 1'b1;
                a++;
                pcyc++;
            end
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        chk("rsp_within_bound", {31'b0, done}, 32'd1);
        chk("psel_cycles", pcyc, v.exp_psel);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
        chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, v.exp_to});
        chk("idle_after_xfer", {30'b0, psel, penable}, 32'd0);
        for (int h = 0; h < v.hold; h++) begin
            cmd_valid = 1'b1;
            cmd_addr  = 16'h0BAD;
            chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            chk("hold_psel", {31'b0, psel}, 32'd0);
            chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("rsp_valid_clear", {31'b0, rsp_valid}, 32'd0);
        chk("paddr_retained", {16'b0, paddr}, {16'b0, v.addr});
        chk("pwdata_retained", pwdata, v.wdata);
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: got hang want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        vecs[0] = '{1'b1, 16'h0004, 32'hDEADBEEF, 0, 32'hFFFFFFFF, 1'b0, 0,
                    32'h0, 1'b0, 1'b0, 2};
        vecs[1] = '{1'b0, 16'h0010, 32'h0, 3, 32'h12345678, 1'b0, 0,
                    32'h12345678, 1'b0, 1'b0, 5};
        vecs[2] = '{1'b0, 16'h0020, 32'h0, 0, 32'hCAFEF00D, 1'b1, 0,
                    32'h0, 1'b1, 1'b0, 2};
        vecs[3] = '{1'b1, 16'h0030, 32'h00001111, 2, 32'h55AA55AA, 1'b1, 0,
                    32'h0, 1'b1, 1'b0, 4};
        vecs[4] = '{1'b0, 16'h0040, 32'h0, 15, 32'hA5A5A5A5, 1'b0, 0,
                    32'hA5A5A5A5, 1'b0, 1'b0, 17};
        vecs[5] = '{1'b0, 16'h0050, 32'h0, 99, 32'h77777777, 1'b0, 0,
                    32'h0, 1'b1, 1'b1, 17};
        vecs[6] = '{1'b1, 16'h0060, 32'h13572468, 0, 32'h0, 1'b0, 10,
                    32'h0, 1'b0, 1'b0, 2};
        vecs[7] = '{1'b0, 16'hFFFF, 32'h0, 1, 32'h87654321, 1'b0, 3,
                    32'h87654321, 1'b0, 1'b0, 3};

        preset_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_psel_pen", {30'b0, psel, penable}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_paddr", {16'b0, paddr}, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_rsp", {rsp_rdata[29:0], rsp_err, rsp_timeout}, 32'd0);
        preset_n = 1'b1;
        @(negedge pclk);
        chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        for (int i = 0; i < 8; i++) run(vecs[i]);

        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0070;
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge pclk);
        chk("pre_rst_access", {30'b0, psel, penable}, 32'd3);
        preset_n = 1'b0;
        #1;
        chk("midrst_psel_pen", {30'b0, psel, penable}, 32'd0);
        chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge pclk);
        preset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            chk("postrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
            chk("postrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("postrst_psel", {31'b0, psel}, 32'd0);
        end
        run(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
